npe_vec_unit: RTL and testbench

NPE_VEC_UNIT -- requirements
Module: npe_vec_unit

---
 rtl/npe_vec_unit_if.sv | 32 +++
 rtl/npe_vec_unit.sv | 165 ++++++++++++++++
 tb/tb_npe_vec_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/npe_vec_unit_if.sv
// Handshake and data bundle for npe_vec_unit: window control, input beats,
// and the held result. The slave side is the unit, the master side drives it.
interface npe_vec_unit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 32,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH,
  parameter int LEN_WIDTH  = 8
);
  logic                          i_start;
  logic [1:0]                    i_mode;
  logic [LEN_WIDTH-1:0]          i_len;
  logic                          i_abort;
  logic [LANES*DATA_WIDTH-1:0]   i_mdata;
  logic [LANES*DATA_WIDTH-1:0]   i_wdata;
  logic                          i_in_vld;
  logic                          o_in_rdy;
  logic [LANES*ACC_WIDTH-1:0]    o_result;
  logic                          o_result_vld;
  logic                          i_result_rdy;
  logic                          o_sat;
  logic                          o_busy;

  modport slave (
    input  i_start, i_mode, i_len, i_abort, i_mdata, i_wdata, i_in_vld, i_result_rdy,
    output o_in_rdy, o_result, o_result_vld, o_sat, o_busy
  );

  modport master (
    output i_start, i_mode, i_len, i_abort, i_mdata, i_wdata, i_in_vld, i_result_rdy,
    input  o_in_rdy, o_result, o_result_vld, o_sat, o_busy
  );
endinterface

// File: rtl/npe_vec_unit.sv
// Windowed SIMD vector unit: per-lane MAC / MAX / ACC / ADD over a window of
// input beats, result held in OUT until the downstream accepts it.
module npe_vec_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_init,
  input  logic                         i_upd,
  input  logic [1:0]                   i_mode,
  input  logic signed [DATA_WIDTH-1:0] i_m,
  input  logic signed [DATA_WIDTH-1:0] i_w,
  output logic [ACC_WIDTH-1:0]         o_acc,
  output logic                         o_sat
);
  localparam logic [1:0] M_MAC = 2'd0, M_MAX = 2'd1, M_ACC = 2'd2, M_ADD = 2'd3;
  // Wide enough that acc + product can never wrap before the clamp.
  localparam int SW = ACC_WIDTH + 2*DATA_WIDTH + 2;
  localparam logic signed [SW-1:0] ACC_MAX_X = SW'({1'b0, {(ACC_WIDTH-1){1'b1}}});
  localparam logic signed [SW-1:0] ACC_MIN_X = ~ACC_MAX_X;
  localparam logic signed [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] MAX_INIT = ACC_WIDTH'(D_MIN);

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [SW-1:0]        acc_x, m_x, w_x, sum_x;
  logic                        sat_v;

  always_comb begin
    acc_x = SW'(acc_q);
    m_x   = SW'(i_m);
    w_x   = SW'(i_w);
    sum_x = '0;
    sat_v = 1'b0;
    acc_d = acc_q;
    case (i_mode)
      M_MAC:   sum_x = acc_x + m_x * w_x;
      M_ACC:   sum_x = acc_x + m_x;
      M_ADD:   sum_x = m_x + w_x;
      default: sum_x = '0;
    endcase
    if (i_init) begin
      acc_d = (i_mode == M_MAX) ? MAX_INIT : '0;
    end else if (i_upd) begin
      if (i_mode == M_MAX) begin
        if (m_x > acc_x) acc_d = ACC_WIDTH'(m_x);
      end else if (sum_x > ACC_MAX_X) begin
        acc_d = ACC_WIDTH'(ACC_MAX_X);
        sat_v = 1'b1;
      end else if (sum_x < ACC_MIN_X) begin
        acc_d = ACC_WIDTH'(ACC_MIN_X);
        sat_v = 1'b1;
      end else begin
        acc_d = ACC_WIDTH'(sum_x);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign o_acc = acc_q;
  assign o_sat = sat_v;
endmodule

module npe_vec_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 32,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH,
  parameter int LEN_WIDTH  = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  npe_vec_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, OUT} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic                   init, beat;
  logic [1:0]             lane_mode;
  logic [LANES-1:0]       lane_sat;
  logic [LANES-1:0][DATA_WIDTH-1:0] m_lanes, w_lanes;
  logic [LANES-1:0][ACC_WIDTH-1:0]  acc_lanes;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    init    = 1'b0;
    beat    = 1'b0;
    case (state_q)
      IDLE: if (bus.i_start) begin
        state_d = RUN;
        mode_d  = bus.i_mode;
        len_d   = (bus.i_len == '0) ? LEN_WIDTH'(1) : bus.i_len;
        cnt_d   = '0;
        sat_d   = 1'b0;
        init    = 1'b1;
      end
      RUN: if (bus.i_abort) begin
        state_d = IDLE;
      end else if (bus.i_in_vld) begin
        beat  = 1'b1;
        sat_d = sat_q | (|lane_sat);
        if (cnt_q == len_q - LEN_WIDTH'(1)) begin
          state_d = OUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
        end
      end
      OUT: if (bus.i_abort || bus.i_result_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Accumulator init must see the mode being latched, not the previous window's.
  assign lane_mode = init ? bus.i_mode : mode_q;
  assign m_lanes   = bus.i_mdata;
  assign w_lanes   = bus.i_wdata;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    npe_vec_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_init (init),
      .i_upd  (beat),
      .i_mode (lane_mode),
      .i_m    (m_lanes[k]),
      .i_w    (w_lanes[k]),
      .o_acc  (acc_lanes[k]),
      .o_sat  (lane_sat[k])
    );
  end

  assign bus.o_result     = acc_lanes;
  assign bus.o_in_rdy     = (state_q == RUN);
  assign bus.o_result_vld = (state_q == OUT);
  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_sat        = sat_q;
endmodule

// File: tb/tb_npe_vec_unit.sv
// Bench for npe_vec_unit: a wide-accumulator and a narrow (8-bit) instance run
// lock-step on identical stimulus and are checked against a per-window model.
module tb_npe_vec_unit;
  localparam int DW = 8, L = 32, AW = 16, AN = 8, LW = 8;
  localparam int W = L*AW;
  typedef logic [W-1:0]    wide_t;
  typedef logic [L*DW-1:0] vec_t;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  npe_vec_unit_if #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) bm ();
  npe_vec_unit_if #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(AN), .LEN_WIDTH(LW)) bn ();

  assign bn.i_start      = bm.i_start;
  assign bn.i_mode       = bm.i_mode;
  assign bn.i_len        = bm.i_len;
  assign bn.i_abort      = bm.i_abort;
  assign bn.i_mdata      = bm.i_mdata;
  assign bn.i_wdata      = bm.i_wdata;
  assign bn.i_in_vld     = bm.i_in_vld;
  assign bn.i_result_rdy = bm.i_result_rdy;

  npe_vec_unit #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bm.slave));
  npe_vec_unit #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(AN), .LEN_WIDTH(LW)) u_nar (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bn.slave));

  int n_cmp = 0, n_bad = 0, win_id = 0;
  vec_t qm[$], qw[$];

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic chk(input string tag, input wide_t obs, input wide_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s win%0d: got %h want %h", tag, win_id, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s win%0d: got %b want %b", tag, win_id, obs, exp);
    end
  endtask

  function automatic longint clampv(input longint v, input int aw, inout bit s);
    longint hi = (longint'(1) <<< (aw-1)) - 1;
    longint lo = -hi - 1;
    if (v > hi) begin s = 1'b1; return hi; end
    if (v < lo) begin s = 1'b1; return lo; end
    return v;
  endfunction

  // Whole-window reference: folds every queued beat through the mode's rule.
  function automatic void model(input logic [1:0] md, output wide_t rm, output wide_t rn,
                                output logic sm, output logic sn);
    bit s16 = 1'b0, s8 = 1'b0;
    longint a16, a8, m, w;
    rm = '0; rn = '0;
    for (int k = 0; k < L; k++) begin
      a16 = (md == 2'd1) ? -128 : 0;
      a8  = a16;
      foreach (qm[b]) begin
        m = $signed(qm[b][k*DW +: DW]);
        w = $signed(qw[b][k*DW +: DW]);
        case (md)
          2'd0: begin a16 = clampv(a16 + m*w, AW, s16); a8 = clampv(a8 + m*w, AN, s8); end
          2'd1: begin if (m > a16) a16 = m; if (m > a8) a8 = m; end
          2'd2: begin a16 = clampv(a16 + m, AW, s16); a8 = clampv(a8 + m, AN, s8); end
          default: begin a16 = clampv(m + w, AW, s16); a8 = clampv(m + w, AN, s8); end
        endcase
      end
      rm[k*AW +: AW] = a16[AW-1:0];
      rn[k*AN +: AN] = a8[AN-1:0];
    end
    sm = s16; sn = s8;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int j = 0; j < L*DW/32; j++) v[j*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic fill_rand(input int n);
    qm.delete(); qw.delete();
    repeat (n) begin qm.push_back(rand_vec()); qw.push_back(rand_vec()); end
  endtask

  // Runs one full window from IDLE using the queued beats, with bp stall cycles in OUT.
  task automatic run_win(input logic [1:0] md, input logic [LW-1:0] ln, input int bp);
    wide_t rm, rn;
    logic sm, sn;
    win_id++;
    model(md, rm, rn, sm, sn);
    bm.i_start = 1'b1; bm.i_mode = md; bm.i_len = ln;
    tick();
    bm.i_start = 1'b0;
    chk1("run.in_rdy", bm.o_in_rdy, 1'b1);
    chk1("run.busy", bm.o_busy, 1'b1);
    foreach (qm[b]) begin
      repeat ($urandom_range(0, 1)) begin bm.i_in_vld = 1'b0; tick(); end
      bm.i_in_vld = 1'b1; bm.i_mdata = qm[b]; bm.i_wdata = qw[b];
      tick();
    end
    bm.i_in_vld = 1'b0;
    chk1("out.vld", bm.o_result_vld, 1'b1);
    chk("out.res_w", bm.o_result, rm);
    chk("out.res_n", wide_t'(bn.o_result), rn);
    chk1("out.sat_w", bm.o_sat, sm);
    chk1("out.sat_n", bn.o_sat, sn);
    repeat (bp) begin
      bm.i_in_vld = 1'b1; bm.i_mdata = rand_vec(); bm.i_wdata = rand_vec();
      bm.i_start = 1'b1; bm.i_mode = 2'($urandom_range(0, 3));
      tick();
      chk1("bp.vld", bm.o_result_vld, 1'b1);
      chk1("bp.in_rdy", bm.o_in_rdy, 1'b0);
      chk("bp.res_w", bm.o_result, rm);
      chk("bp.res_n", wide_t'(bn.o_result), rn);
      chk1("bp.sat_n", bn.o_sat, sn);
    end
    bm.i_in_vld = 1'b0; bm.i_start = 1'b0; bm.i_result_rdy = 1'b1;
    tick();
    bm.i_result_rdy = 1'b0;
    chk1("done.vld", bm.o_result_vld, 1'b0);
    chk1("done.busy", bm.o_busy, 1'b0);
  endtask

  initial begin
    vec_t v;
    i_rst = 1'b1;
    bm.i_start = 1'b0; bm.i_mode = '0; bm.i_len = '0; bm.i_abort = 1'b0;
    bm.i_mdata = '0; bm.i_wdata = '0; bm.i_in_vld = 1'b0; bm.i_result_rdy = 1'b0;
    tick(); tick();
    chk("rst.res_w", bm.o_result, '0);
    chk("rst.res_n", wide_t'(bn.o_result), '0);
    chk1("rst.vld", bm.o_result_vld, 1'b0);
    chk1("rst.in_rdy", bm.o_in_rdy, 1'b0);
    chk1("rst.busy", bm.o_busy, 1'b0);
    chk1("rst.sat", bm.o_sat, 1'b0);
    i_rst = 1'b0;
    tick();

    // MAC 3 beats of 2*3 -> 18 per lane
    qm.delete(); qw.delete();
    repeat (3) begin qm.push_back({L{8'sd2}}); qw.push_back({L{8'sd3}}); end
    run_win(2'd0, 8'd3, 0);

    // MAX with a 5-cycle stall in OUT; lane0 -> 7, others stay -128
    qm.delete(); qw.delete();
    foreach (qm[b]) qm.delete();
    v = {L{8'h80}}; v[7:0] = 8'hFB; qm.push_back(v);
    v[7:0] = 8'h07; qm.push_back(v);
    v[7:0] = 8'h80; qm.push_back(v);
    v[7:0] = 8'h03; qm.push_back(v);
    repeat (4) qw.push_back(rand_vec());
    run_win(2'd1, 8'd4, 5);

    // ACC 100+100: narrow lanes clamp to 127, then a clean window clears o_sat
    qm.delete(); qw.delete();
    repeat (2) begin qm.push_back({L{8'sd100}}); qw.push_back(rand_vec()); end
    run_win(2'd2, 8'd2, 1);
    qm.delete(); qw.delete();
    qm.push_back({L{8'sd1}}); qw.push_back(rand_vec());
    run_win(2'd2, 8'd1, 0);

    // ADD with len 0 behaves as one beat: -3 + 10
    qm.delete(); qw.delete();
    qm.push_back({L{8'hFD}}); qw.push_back({L{8'sd10}});
    run_win(2'd3, 8'd0, 2);

    // Abort after 2 of 4 MAC beats; abort beats the simultaneous input beat
    win_id++;
    bm.i_start = 1'b1; bm.i_mode = 2'd0; bm.i_len = 8'd4;
    tick();
    bm.i_start = 1'b0;
    repeat (2) begin bm.i_in_vld = 1'b1; bm.i_mdata = rand_vec(); bm.i_wdata = rand_vec(); tick(); end
    bm.i_abort = 1'b1;
    tick();
    bm.i_abort = 1'b0; bm.i_in_vld = 1'b0;
    chk1("abort.busy", bm.o_busy, 1'b0);
    chk1("abort.in_rdy", bm.o_in_rdy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk1("abort.vld", bm.o_result_vld, 1'b0);
      tick();
    end

    // Abort in OUT wins over a simultaneous result accept
    fill_rand(1);
    win_id++;
    bm.i_start = 1'b1; bm.i_mode = 2'd3; bm.i_len = 8'd1;
    tick();
    bm.i_start = 1'b0; bm.i_in_vld = 1'b1; bm.i_mdata = qm[0]; bm.i_wdata = qw[0];
    tick();
    bm.i_in_vld = 1'b0;
    chk1("oabort.vld_pre", bm.o_result_vld, 1'b1);
    bm.i_abort = 1'b1; bm.i_result_rdy = 1'b1;
    tick();
    bm.i_abort = 1'b0; bm.i_result_rdy = 1'b0;
    chk1("oabort.vld", bm.o_result_vld, 1'b0);
    chk1("oabort.busy", bm.o_busy, 1'b0);
    tick();

    // Reset mid-RUN, then a fresh window
    win_id++;
    bm.i_start = 1'b1; bm.i_mode = 2'd2; bm.i_len = 8'd4;
    tick();
    bm.i_start = 1'b0;
    repeat (2) begin bm.i_in_vld = 1'b1; bm.i_mdata = {L{8'sd100}}; tick(); end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0; bm.i_in_vld = 1'b0;
    chk("mrst.res_w", bm.o_result, '0);
    chk("mrst.res_n", wide_t'(bn.o_result), '0);
    chk1("mrst.vld", bm.o_result_vld, 1'b0);
    chk1("mrst.in_rdy", bm.o_in_rdy, 1'b0);
    chk1("mrst.busy", bm.o_busy, 1'b0);
    chk1("mrst.sat", bn.o_sat, 1'b0);
    fill_rand(3);
    run_win(2'd0, 8'd3, 1);

    // Randomized windows across all modes and short lengths
    for (int r = 0; r < 16; r++) begin
      logic [LW-1:0] ln;
      ln = LW'($urandom_range(0, 5));
      fill_rand((ln == 0) ? 1 : int'(ln));
      run_win(2'($urandom_range(0, 3)), ln, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
